y_drain: RTL and testbench
==========================

# y_drain

Output-side drain stage sitting directly downstream of the processing unit's output buffer. After the PU signals completion, the block reads `len` int32 accumulator words from the y buffer and requantizes each to int8 with an arithmetic right shift and saturation. It packs four results per 32-bit word and streams them out over a valid/ready interface to the host/DMA side. This closes the int8 streamline path: int8 in, int32 accumulate, int8 out.

## Interface
- `ADDR_WIDTH`, 32, y buffer address width
- `DATA_WIDTH`, 32, y buffer word width (int32 accumulator)
- `LEN_WIDTH`, 16, element count width
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, synchronous, active-high
- `drain_start` in 1: one-cycle start pulse; ignored while `busy`
- `drain_base` in ADDR_WIDTH: first y buffer address, sampled on start
- `drain_len` in LEN_WIDTH: number of int32 elements, sampled on start
- `shift` in 5: right-shift amount 0..31, sampled on start
- `busy` out 1: high from the cycle after an accepted start until the done pulse
- `drain_done` out 1: one-cycle pulse at end of drain
- `y_buf_en` out 1: read enable
- `y_buf_addr` out ADDR_WIDTH: read address
- `y_buf_data` in DATA_WIDTH: read data, valid exactly 1 cycle after `y_buf_en`
- `m_valid` out 1: packed word valid
- `m_ready` in 1: consumer ready
- `m_data` out 32: lane k in bits [8k+7:8k]
- `m_last` out 1: final word of the drain, qualified by `m_valid`

## Operation
- FSM: IDLE -> READ (start accepted, len>0) -> FLUSH (all reads issued, waiting for last handshake) -> DONE (1 cycle, `drain_done`=1) -> IDLE.
- Zero-length start goes IDLE -> DONE directly.
- Element i is read from `drain_base+i`. Lane is i mod 4.
- Requant: arithmetic shift right by `shift`, then saturate to [-128,127].
- Pack register collects lanes 0..3. When the lane-3 element arrives, or the final element arrives, the pack register moves to the output register. Unused lanes are zero.
- Read issue rule: reads for lanes 0-2 issue every cycle. A read whose element will complete a word (lane 3 or final) issues only if the output register is empty or `m_valid && m_ready` in that cycle. Otherwise `y_buf_en` stays low and the address holds.
- `m_data`/`m_last` stay stable while `m_valid && !m_ready`.
- `rst` at any time: return to IDLE, clear all registers, no done pulse, drop any in-flight word.

## Timing
- Reset values: `busy`, `drain_done`, `y_buf_en`, `m_valid`, `m_last` = 0; `y_buf_addr`, `m_data` = 0.
- Start sampled in cycle 0; first `y_buf_en` in cycle 1.
- An element read in cycle c is captured at the end of c+1.
- A completed word shows `m_valid` in c+2 of its last read. With len≥4 and `m_ready` held high, the first `m_valid` is in cycle 6.
- Sustained throughput: 1 element per cycle (1 word per 4 cycles) when `m_ready`=1.
- `drain_done` is asserted in the cycle after the `m_last` handshake. For len=0, `drain_done` is asserted in cycle 1.

## Configuration
- `Y_DRAIN_ROUND_EN` defined: round half up. Add `1<<(shift-1)` before the shift when shift>0; the addition is performed in 33 bits so it cannot overflow.
- `Y_DRAIN_ROUND_EN` undefined: plain arithmetic shift, which truncates toward minus infinity.

## Structure
- Package `y_drain_pkg` holds:
  - FSM state enum
  - `LANES`=4
  - `INT8_MAX`=127 and `INT8_MIN`=-128
- Sub-module `y_requant`: combinational round/shift/saturate from int32 to int8. It contains the `Y_DRAIN_ROUND_EN` switch.

## Test plan
- len=4, shift=0, data {100,-300,127,128} -> one word `m_data`=0x7F7F8064, `m_last`=1, `drain_done` the cycle after the handshake.
- len=4, shift=4, data {24,-24,7,8} -> 0x0100FF02 with `Y_DRAIN_ROUND_EN`; 0x0000FE01 without.
- len=6 -> two words; second word has lanes 2-3 = 0x00 and `m_last`=1; reads cover addresses base..base+5 exactly once.
- len=8, `m_ready` low for 10 cycles after the first `m_valid` -> `m_data` stable; addresses base+4..base+6 are read and base+7 is held until the handshake; no data loss or duplication.
- len=0 -> `drain_done` in cycle 1, `m_valid` never asserted, no `y_buf_en`.
- `rst` during READ -> all outputs at reset values the next cycle and no `drain_done`; a subsequent start drains correctly from the start.

Source files
------------

// File: rtl/y_drain_pkg.sv
// Shared types and constants for the y_drain output requantization stage.
package y_drain_pkg;

  localparam int unsigned LANES    = 4;
  localparam int          INT8_MAX = 127;
  localparam int          INT8_MIN = -128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/y_drain_requant.sv
// Combinational int32 -> int8 requantizer: optional round-half-up, arithmetic shift, saturate.
// Build option: Y_DRAIN_ROUND_EN enables round half up before the shift.
module y_requant
  import y_drain_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] acc,
  input  logic [4:0]            shift,
  output logic [7:0]            q
);

  localparam int unsigned EXT_W = DATA_WIDTH + 1;
  localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'(INT8_MAX);
  localparam logic signed [EXT_W-1:0] SAT_LO = EXT_W'(INT8_MIN);

  logic signed [EXT_W-1:0] acc_ext;
  logic signed [EXT_W-1:0] biased;
  logic signed [EXT_W-1:0] shifted;
`ifdef Y_DRAIN_ROUND_EN
  logic signed [EXT_W-1:0] round_inc;
`endif

  // Widen by one bit so the rounding add cannot overflow, then shift and clamp.
  always_comb begin
    acc_ext = {acc[DATA_WIDTH-1], acc};
`ifdef Y_DRAIN_ROUND_EN
    round_inc = '0;
    if (shift != 5'd0) begin
      round_inc = EXT_W'(1) << (shift - 5'd1);
    end
    biased = acc_ext + round_inc;
`else
    biased = acc_ext;
`endif
    shifted = biased >>> shift;
    if (shifted > SAT_HI) begin
      q = 8'h7F;
    end else if (shifted < SAT_LO) begin
      q = 8'h80;
    end else begin
      q = shifted[7:0];
    end
  end

endmodule

// File: rtl/y_drain.sv
// Drains int32 accumulators from the y buffer, requantizes to int8 and streams packed words.
// Build option: Y_DRAIN_ROUND_EN (handled in y_requant) selects round-half-up requantization.
module y_drain
  import y_drain_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  drain_start,
  input  logic [ADDR_WIDTH-1:0] drain_base,
  input  logic [LEN_WIDTH-1:0]  drain_len,
  input  logic [4:0]            shift,
  output logic                  busy,
  output logic                  drain_done,
  output logic                  y_buf_en,
  output logic [ADDR_WIDTH-1:0] y_buf_addr,
  input  logic [DATA_WIDTH-1:0] y_buf_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [31:0]           m_data,
  output logic                  m_last
);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [4:0]             shift_q, shift_d;
  logic [LEN_WIDTH-1:0]   rd_idx_q, rd_idx_d;
  logic                   cap_vld_q, cap_vld_d;
  logic [1:0]             cap_lane_q, cap_lane_d;
  logic                   cap_cmpl_q, cap_cmpl_d;
  logic                   cap_last_q, cap_last_d;
  logic [31:0]            pack_q, pack_d;
  logic                   out_vld_q, out_vld_d;
  logic [31:0]            out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;

  logic [1:0]  rd_lane;
  logic        rd_final;
  logic        rd_completes;
  logic        out_free;
  logic        rd_en_c;
  logic [7:0]  q8;
  logic [31:0] merged;

  y_requant #(.DATA_WIDTH(DATA_WIDTH)) u_requant (
    .acc   (y_buf_data),
    .shift (shift_q),
    .q     (q8)
  );

  // Read gating: a word-completing read waits until the output register will be free.
  always_comb begin
    rd_lane      = rd_idx_q[1:0];
    rd_final     = (rd_idx_q == (len_q - LEN_WIDTH'(1)));
    rd_completes = (rd_lane == 2'(LANES - 1)) || rd_final;
    out_free     = !out_vld_q || m_ready;
    rd_en_c      = (state_q == ST_READ) && (!rd_completes || out_free);
  end

  // Next-state, read sequencing, lane packing and output register update.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    shift_d    = shift_q;
    rd_idx_d   = rd_idx_q;
    cap_vld_d  = rd_en_c;
    cap_lane_d = rd_lane;
    cap_cmpl_d = rd_completes;
    cap_last_d = rd_final;
    pack_d     = pack_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    merged     = pack_q | (32'(q8) << {cap_lane_q, 3'b000});

    if (out_vld_q && m_ready) begin
      out_vld_d  = 1'b0;
      out_last_d = 1'b0;
    end

    if (cap_vld_q) begin
      if (cap_cmpl_q) begin
        out_data_d = merged;
        out_vld_d  = 1'b1;
        out_last_d = cap_last_q;
        pack_d     = '0;
      end else begin
        pack_d = merged;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (drain_start) begin
          addr_d   = drain_base;
          len_d    = drain_len;
          shift_d  = shift;
          rd_idx_d = '0;
          pack_d   = '0;
          state_d  = (drain_len == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        if (rd_en_c) begin
          addr_d   = addr_q + ADDR_WIDTH'(1);
          rd_idx_d = rd_idx_q + LEN_WIDTH'(1);
          if (rd_final) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (out_vld_q && m_ready && out_last_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      shift_q    <= '0;
      rd_idx_q   <= '0;
      cap_vld_q  <= 1'b0;
      cap_lane_q <= '0;
      cap_cmpl_q <= 1'b0;
      cap_last_q <= 1'b0;
      pack_q     <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      shift_q    <= shift_d;
      rd_idx_q   <= rd_idx_d;
      cap_vld_q  <= cap_vld_d;
      cap_lane_q <= cap_lane_d;
      cap_cmpl_q <= cap_cmpl_d;
      cap_last_q <= cap_last_d;
      pack_q     <= pack_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign drain_done = (state_q == ST_DONE);
  assign y_buf_en   = rd_en_c;
  assign y_buf_addr = addr_q;
  assign m_valid    = out_vld_q;
  assign m_data     = out_data_q;
  assign m_last     = out_last_q;

endmodule

// File: tb/tb_y_drain.sv
// Scoreboard bench for y_drain: directed drains, backpressure, zero length and mid-drain reset.
module tb_y_drain;

  logic        clk;
  logic        rst;
  logic        drain_start;
  logic [31:0] drain_base;
  logic [15:0] drain_len;
  logic [4:0]  shift;
  logic        busy;
  logic        drain_done;
  logic        y_buf_en;
  logic [31:0] y_buf_addr;
  logic [31:0] y_buf_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;

  y_drain dut (
    .clk         (clk),
    .rst         (rst),
    .drain_start (drain_start),
    .drain_base  (drain_base),
    .drain_len   (drain_len),
    .shift       (shift),
    .busy        (busy),
    .drain_done  (drain_done),
    .y_buf_en    (y_buf_en),
    .y_buf_addr  (y_buf_addr),
    .y_buf_data  (y_buf_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rd_log[$];
  logic [31:0] mem [0:255];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int first_valid_cyc = -1;
  int last_hs_cyc = -1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // One-cycle read latency y buffer model.
  always @(posedge clk) begin
    if (y_buf_en) y_buf_data <= mem[y_buf_addr[7:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: logs reads, checks hold stability and pops the scoreboard on each handshake.
  initial begin : monitor
    logic        held;
    logic [31:0] held_data;
    logic        held_last;
    exp_t        e;
    held = 1'b0;
    held_data = '0;
    held_last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (y_buf_en) rd_log.push_back(y_buf_addr);
        if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (held) begin
          chk("hold_valid", 32'(m_valid), 32'd1);
          chk("hold_data", m_data, held_data);
          chk("hold_last", 32'(m_last), 32'(held_last));
        end
        held      = m_valid && !m_ready;
        held_data = m_data;
        held_last = m_last;
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", m_data, 32'hDEAD_BEEF);
          end else begin
            e = exp_q.pop_front();
            chk("m_data", m_data, e.d);
            chk("m_last", 32'(m_last), 32'(e.l));
            if (m_last) last_hs_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic start_drain(input logic [31:0] base, input logic [15:0] len, input logic [4:0] sh);
    @(posedge clk); #1;
    drain_base      = base;
    drain_len       = len;
    shift           = sh;
    drain_start     = 1'b1;
    start_cyc       = cyc;
    first_valid_cyc = -1;
    last_hs_cyc     = -1;
    rd_log.delete();
    @(posedge clk); #1;
    drain_start = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    bit seen;
    seen = 1'b0;
    dc = -1;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (drain_done) begin
        seen = 1'b1;
        dc = cyc;
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reads(input logic [31:0] base, input int len);
    chk("rd_count", 32'(rd_log.size()), 32'(len));
    for (int i = 0; i < len; i++) begin
      if (i < rd_log.size()) chk("rd_addr", rd_log[i], base + 32'(i));
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(drain_done), 32'd0);
    chk("rst_en", 32'(y_buf_en), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_addr", y_buf_addr, 32'd0);
    chk("rst_data", m_data, 32'd0);
  endtask

  initial begin : stim
    int dc;
    bit seen_done;
    rst = 1'b1;
    drain_start = 1'b0;
    drain_base = '0;
    drain_len = '0;
    shift = '0;
    m_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;

    // Saturation both ways, shift 0, first-valid latency and done timing.
    mem[8'h10] = 32'd100; mem[8'h11] = 32'hFFFF_FED4; mem[8'h12] = 32'd127; mem[8'h13] = 32'd128;
    exp_q.push_back('{d: 32'h7F7F_8064, l: 1'b1});
    start_drain(32'h10, 16'd4, 5'd0);
    wait_done(dc);
    chk("t1_first_valid", 32'(first_valid_cyc - start_cyc), 32'd6);
    chk("t1_done_after_last", 32'(dc - last_hs_cyc), 32'd1);
    check_reads(32'h10, 4);
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Shift 4 with rounding build option.
    mem[8'h20] = 32'd24; mem[8'h21] = 32'hFFFF_FFE8; mem[8'h22] = 32'd7; mem[8'h23] = 32'd8;
`ifdef Y_DRAIN_ROUND_EN
    exp_q.push_back('{d: 32'h0100_FF02, l: 1'b1});
`else
    exp_q.push_back('{d: 32'h0000_FE01, l: 1'b1});
`endif
    start_drain(32'h20, 16'd4, 5'd4);
    wait_done(dc);
    chk("t2_done_after_last", 32'(dc - last_hs_cyc), 32'd1);
    chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // Partial final word.
    for (int i = 0; i < 6; i++) mem[8'h30 + i] = 32'(i + 1);
    exp_q.push_back('{d: 32'h0403_0201, l: 1'b0});
    exp_q.push_back('{d: 32'h0000_0605, l: 1'b1});
    start_drain(32'h30, 16'd6, 5'd0);
    wait_done(dc);
    chk("t3_done_after_last", 32'(dc - last_hs_cyc), 32'd1);
    check_reads(32'h30, 6);
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure: ready low for 10 cycles from the first valid word.
    for (int i = 0; i < 8; i++) mem[8'h40 + i] = 32'(2 * (i + 1));
    exp_q.push_back('{d: 32'h0403_0201, l: 1'b0});
    exp_q.push_back('{d: 32'h0807_0605, l: 1'b1});
    m_ready = 1'b0;
    start_drain(32'h40, 16'd8, 5'd1);
    for (int i = 0; i < 50 && !m_valid; i++) @(negedge clk);
    chk("t4_first_valid", 32'(cyc - start_cyc), 32'd6);
    repeat (4) @(negedge clk);
    chk("t4_stall_en", 32'(y_buf_en), 32'd0);
    chk("t4_stall_addr", y_buf_addr, 32'h47);
    chk("t4_stall_reads", 32'(rd_log.size()), 32'd7);
    repeat (6) @(posedge clk);
    #1;
    m_ready = 1'b1;
    wait_done(dc);
    chk("t4_done_after_last", 32'(dc - last_hs_cyc), 32'd1);
    check_reads(32'h40, 8);
    chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // Zero length: done in cycle 1, no reads, no output.
    start_drain(32'h50, 16'd0, 5'd0);
    wait_done(dc);
    chk("t5_done_cycle", 32'(dc - start_cyc), 32'd1);
    chk("t5_no_reads", 32'(rd_log.size()), 32'd0);
    chk("t5_no_valid", 32'(first_valid_cyc), 32'hFFFF_FFFF);

    // Reset in the middle of READ, then a clean drain.
    start_drain(32'h60, 16'd8, 5'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (drain_done) seen_done = 1'b1;
    end
    chk("t6_no_done", 32'(seen_done), 32'd0);

    mem[8'h70] = 32'hFFFF_FFFF; mem[8'h71] = 32'h7FFF_FFFF; mem[8'h72] = 32'h8000_0000; mem[8'h73] = 32'd5;
    exp_q.push_back('{d: 32'h0580_7FFF, l: 1'b1});
    start_drain(32'h70, 16'd4, 5'd0);
    wait_done(dc);
    chk("t6_first_valid", 32'(first_valid_cyc - start_cyc), 32'd6);
    chk("t6_done_after_last", 32'(dc - last_hs_cyc), 32'd1);
    check_reads(32'h70, 4);
    chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
